// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush arbiter for an N-stage in-order pipeline.
// It adds load-use bubbles, defers redirects that arrive during a memory stall,
// runs a memory-wait watchdog, and keeps performance counters.
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES     = 5,
    parameter int HAZARD_STAGE   = 2,
    parameter int FLUSH_DEPTH    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  branch_req,
    input  logic                  load_use_req,
    input  logic                  imem_busy,
    input  logic                  dmem_busy,
    input  logic                  clr_perf,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  redirect_pending_o,
    output logic                  timeout_o,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      flush_events_o
);

    localparam bit                WD_EN  = (TIMEOUT_CYCLES > 0);
    localparam int                WD_W   = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0]   WD_MAX = WD_EN ? WD_W'(TIMEOUT_CYCLES) : '0;

    // Reject parameter sets that would index outside the stage vector
    generate
        if (HAZARD_STAGE < 1 || HAZARD_STAGE > NUM_STAGES - 2) begin : g_bad_hazard
            $error("pipeline_hazard_ctrl: HAZARD_STAGE out of range");
        end
        if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > NUM_STAGES - 2) begin : g_bad_flush
            $error("pipeline_hazard_ctrl: FLUSH_DEPTH out of range");
        end
        if (TIMEOUT_CYCLES < 0) begin : g_bad_timeout
            $error("pipeline_hazard_ctrl: TIMEOUT_CYCLES must be non-negative");
        end
    endgenerate

    typedef enum logic {IDLE, PENDING} pend_state_t;

    pend_state_t     state, state_nxt;
    logic            mem_busy;
    logic            redirect;
    logic            fire_redirect;
    logic [WD_W-1:0] wd_cnt;

    assign mem_busy           = imem_busy | dmem_busy;
    assign redirect           = branch_req | (state == PENDING);
    assign redirect_pending_o = (state == PENDING);

    // Priority arbitration: memory stall, then redirect flush, then load-use bubble
    always_comb begin
        stall_o       = '0;
        flush_o       = '0;
        fire_redirect = 1'b0;
        if (mem_busy) begin
            stall_o = '1;
        end else if (redirect) begin
            // Any load-use hit this cycle is on the wrong path, so it is dropped.
            fire_redirect = 1'b1;
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (k <= FLUSH_DEPTH) flush_o[k] = 1'b1;
            end
        end else if (load_use_req) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (k < HAZARD_STAGE) stall_o[k] = 1'b1;
            end
            flush_o[HAZARD_STAGE] = 1'b1;
        end
    end

    // Pending redirect: hold a branch caught under a memory stall until the stall clears.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (branch_req && mem_busy) state_nxt = PENDING;
            PENDING: if (!mem_busy)              state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pending state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Watchdog: counts consecutive busy cycles; the timeout flag is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (!mem_busy || !WD_EN)  wd_cnt <= '0;
            else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_W'(1);
            // The flag rises on the same edge that the count reaches the limit.
            if (WD_EN && mem_busy && (wd_cnt >= WD_MAX - WD_W'(1))) timeout_o <= 1'b1;
        end
    end

    // Performance counters: they wrap freely, and a clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_o <= '0;
            flush_events_o <= '0;
        end else if (clr_perf) begin
            stall_cycles_o <= '0;
            flush_events_o <= '0;
        end else begin
            if (|stall_o)      stall_cycles_o <= stall_cycles_o + CNT_W'(1);
            if (fire_redirect) flush_events_o <= flush_events_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (default stage geometry, watchdog limit 4).
module tb_pipeline_hazard_ctrl;

    localparam int NS = 5;
    localparam int TO = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          branch_req, load_use_req, imem_busy, dmem_busy, clr_perf;
    logic [NS-1:0] stall_o, flush_o;
    logic          redirect_pending_o, timeout_o;
    logic [CW-1:0] stall_cycles_o, flush_events_o;

    pipeline_hazard_ctrl #(
        .NUM_STAGES(NS), .HAZARD_STAGE(2), .FLUSH_DEPTH(2),
        .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .branch_req(branch_req), .load_use_req(load_use_req),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .clr_perf(clr_perf),
        .stall_o(stall_o), .flush_o(flush_o),
        .redirect_pending_o(redirect_pending_o), .timeout_o(timeout_o),
        .stall_cycles_o(stall_cycles_o), .flush_events_o(flush_events_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] stall;
        logic [NS-1:0] flush;
        logic          pend;
        logic          to;
        logic [CW-1:0] sc;
        logic [CW-1:0] fe;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon_e;
    logic          m_pend, m_to;
    int            m_wd;
    logic [CW-1:0] m_sc, m_fe;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then advance the reference model.
    task automatic drive(input logic rst, input logic br, input logic lu,
                         input logic ib, input logic db, input logic clr);
        exp_t e;
        logic mb, rd;
        @(posedge clk); #1;
        reset = rst; branch_req = br; load_use_req = lu;
        imem_busy = ib; dmem_busy = db; clr_perf = clr;
        if (rst) begin
            m_pend = 1'b0; m_to = 1'b0; m_wd = 0; m_sc = '0; m_fe = '0;
        end
        mb = ib | db;
        rd = br | m_pend;
        e.stall = '0;
        e.flush = '0;
        if (mb)      e.stall = 5'b11111;
        else if (rd) e.flush = 5'b00111;
        else if (lu) begin
            e.stall = 5'b00011;
            e.flush = 5'b00100;
        end
        e.pend = m_pend; e.to = m_to; e.sc = m_sc; e.fe = m_fe;
        sbq.push_back(e);
        if (!rst) begin
            if (!m_pend && br && mb) m_pend = 1'b1;
            else if (m_pend && !mb)  m_pend = 1'b0;
            if (mb && m_wd >= TO - 1) m_to = 1'b1;
            if (!mb)          m_wd = 0;
            else if (m_wd < TO) m_wd++;
            if (clr)                m_sc = '0;
            else if (e.stall != '0) m_sc = m_sc + 1;
            if (clr)           m_fe = '0;
            else if (!mb && rd) m_fe = m_fe + 1;
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation at mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("stall", 64'(stall_o), 64'(mon_e.stall));
            check("flush", 64'(flush_o), 64'(mon_e.flush));
            check("excl", 64'(stall_o & flush_o), 64'(0));
            check("pending", 64'(redirect_pending_o), 64'(mon_e.pend));
            check("timeout", 64'(timeout_o), 64'(mon_e.to));
            check("stall_cycles", 64'(stall_cycles_o), 64'(mon_e.sc));
            check("flush_events", 64'(flush_events_o), 64'(mon_e.fe));
        end
    end

    initial begin
        reset = 1'b1; branch_req = 0; load_use_req = 0;
        imem_busy = 0; dmem_busy = 0; clr_perf = 0;
        m_pend = 0; m_to = 0; m_wd = 0; m_sc = '0; m_fe = '0;
        repeat (2) drive(1, 0, 0, 0, 0, 0);
        // Idle after reset
        repeat (5) drive(0, 0, 0, 0, 0, 0);
        // Single load-use bubble
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        // Branch that arrives under a 3-cycle data stall is deferred
        drive(0, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t3_flush_events", 64'(flush_events_o), 64'(1));
        check("t3_stall_cycles", 64'(stall_cycles_o), 64'(4));
        // A branch masks a same-cycle load-use hit
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        // Watchdog trips after 4 busy cycles and stays set
        repeat (6) drive(0, 0, 0, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t5_timeout_sticky", 64'(timeout_o), 64'(1));
        // A clear wins over a same-cycle increment
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t6_clr_sc", 64'(stall_cycles_o), 64'(0));
        check("t6_clr_fe", 64'(flush_events_o), 64'(0));
        // Reset while a redirect is pending and the watchdog is counting
        drive(0, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t6_reset_pending", 64'(redirect_pending_o), 64'(0));
        check("t6_reset_flush", 64'(flush_o), 64'(0));
        // Random traffic
        repeat (300) drive(0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                           $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 40) == 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("sb_drained", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
